// File: rtl/avalon_burst_master.sv
// Avalon-MM burst master: the SRAM access engine for the edge-detection datapath.
// Takes one read/write command with base address and beat count, and issues
// sequential single-word transfers at incrementing addresses. It honours
// waitrequest and readdatavalid, with one outstanding read at a time.
// Optional feature: define RD_TIMEOUT_EN to abort a read that gets no
// readdatavalid within TIMEOUT_CYC cycles. The command then ends with
// done and error both high.
module avalon_burst_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 255,
  localparam int LEN_W      = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              error,
  // Avalon-MM master side
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  // Reject parameter sets the datapath cannot represent.
  if ((DATA_W % 8) != 0 || TIMEOUT_CYC < 1 || MAX_BURST < 1) begin : g_bad_param
    $error("avalon_burst_master: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_CMD  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   beats_left;

  // A length of 0 means one beat; anything above MAX_BURST is clamped.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return LEN_W'(1);
    else if (len > LEN_W'(MAX_BURST))
      return LEN_W'(MAX_BURST);
    else
      return len;
  endfunction

`ifdef RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            error_r;

  // The counter starts at 0 on the first RD_WAIT cycle. The abort happens on
  // the TIMEOUT_CYC-th waiting cycle, so done lands TIMEOUT_CYC cycles after
  // the block enters RD_WAIT.
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign error  = error_r;
`else
  assign error  = 1'b0;
`endif

  // Bus strobes are decoded from the state register, so they are glitch-free
  // and drop low in the cycle after a reset.
  assign cmd_ready = (state == IDLE);
  assign write     = (state == WR);
  assign read      = (state == RD_CMD);
  assign done      = (state == DONE);
  assign writedata = write ? wdata : '0;
  assign wdata_ack = write && !waitrequest;

  // Command FSM: latch the command, step through the beats, then spend one DONE cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      address     <= '0;
      beats_left  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
`ifdef RD_TIMEOUT_EN
      to_cnt      <= '0;
      error_r     <= 1'b0;
`endif
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            address    <= cmd_addr;
            beats_left <= eff_len(cmd_len);
`ifdef RD_TIMEOUT_EN
            error_r    <= 1'b0;
`endif
            state      <= cmd_write ? WR : RD_CMD;
          end
        end

        WR: begin
          if (!waitrequest) begin
            address    <= address + STRIDE;
            beats_left <= beats_left - LEN_W'(1);
            if (beats_left == LEN_W'(1))
              state <= DONE;
          end
        end

        RD_CMD: begin
          if (!waitrequest) begin
`ifdef RD_TIMEOUT_EN
            to_cnt <= '0;
`endif
            state  <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (readdatavalid) begin
            rdata       <= readdata;
            rdata_valid <= 1'b1;
            if (beats_left > LEN_W'(1)) begin
              address    <= address + STRIDE;
              beats_left <= beats_left - LEN_W'(1);
              state      <= RD_CMD;
            end else begin
              beats_left <= '0;
              state      <= DONE;
            end
          end
`ifdef RD_TIMEOUT_EN
          else if (to_hit) begin
            // Drop the remaining beats and report the failure with done.
            beats_left <= '0;
            error_r    <= 1'b1;
            state      <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Testbench for avalon_burst_master. A command driver pushes the expected bus
// transfers, read data and completions into queues. A separate monitor pops
// and compares them whenever the DUT shows activity. A slave model supplies
// waitrequest and delayed read data.
module tb_avalon_burst_master;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MB  = 16;
  localparam int TMO = 8;
  localparam int LW  = $clog2(MB + 1);

  logic          clk;
  logic          n_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdata;
  logic          wdata_ack;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;
  logic          error;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  avalon_burst_master #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .error(error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    bit wr;
    bit tmo;
    int first_cyc;
  } cmd_t;

  xfer_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  logic [31:0] slave_q[$];
  cmd_t        cmd_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  bit started = 0;
  int last_beat_cyc = 0;
  int last_rv_cyc = 0;
  int rd_acc_cyc = 0;

  int sl_mode = 0;
  bit no_resp = 0;
  int lat_max = 1;
  int hold = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Slave model: stall generation and read responses with a random latency.
  initial begin
    bit acc;
    int rcnt;
    rcnt = 0;
    waitrequest = 1'b0;
    readdatavalid = 1'b0;
    readdata = '0;
    forever begin
      @(negedge clk);
      acc = read && !waitrequest && !no_resp;
      @(posedge clk);
      #1;
      readdatavalid = 1'b0;
      if (acc) rcnt = $urandom_range(lat_max, 1);
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          readdatavalid = 1'b1;
          readdata = (slave_q.size() != 0) ? slave_q.pop_front() : 32'h0BAD0BAD;
        end
      end
      case (sl_mode)
        1:       waitrequest = ($urandom_range(3, 0) == 0);
        2: begin
          if (write && address == 32'h104 && hold < 3) begin
            waitrequest = 1'b1;
            hold++;
          end else begin
            waitrequest = 1'b0;
          end
        end
        default: waitrequest = 1'b0;
      endcase
    end
  end

  // Monitor: compares every DUT output event against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      xfer_t e;
      cmd_t  c;
      chk("rd_wr_exclusive", {63'd0, read && write}, 64'd0);
      chk("wdata_ack", {63'd0, wdata_ack}, {63'd0, write && !waitrequest});
      if (!write) chk("writedata_idle", 64'(writedata), 64'd0);
      if (read || write) begin
        if (exp_bus.size() == 0) begin
          chk("unexpected_xfer", {63'd0, write}, 64'd2);
        end else begin
          e = exp_bus[0];
          chk("xfer_kind", {63'd0, write}, {63'd0, e.wr});
          chk("address", 64'(address), 64'(e.addr));
          if (write) chk("writedata", 64'(writedata), 64'(e.data));
          if (!started) begin
            started = 1;
            if (cmd_q.size() != 0) chk("first_xfer_cycle", 64'(cyc), 64'(cmd_q[0].first_cyc));
          end
          if (!waitrequest) begin
            void'(exp_bus.pop_front());
            if (write) last_beat_cyc = cyc;
            else rd_acc_cyc = cyc;
          end
        end
      end
      if (rdata_valid) begin
        if (exp_rd.size() == 0) chk("unexpected_rdata_valid", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rdata", 64'(rdata), 64'(exp_rd.pop_front()));
        last_rv_cyc = cyc;
      end
      if (done) begin
        chk("done_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        if (cmd_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          c = cmd_q.pop_front();
          chk("error", {63'd0, error}, {63'd0, c.tmo});
          chk("beats_left_at_done", 64'(exp_bus.size() + exp_rd.size()), 64'd0);
          if (c.tmo) chk("timeout_done_cycle", 64'(cyc), 64'(rd_acc_cyc + 1 + TMO));
          else if (c.wr) chk("wr_done_cycle", 64'(cyc), 64'(last_beat_cyc + 1));
          else chk("rd_done_cycle", 64'(cyc), 64'(last_rv_cyc));
        end
        started = 0;
        done_cnt++;
      end
    end
  end

  // Present a command and return after acceptance with cmd_valid low again.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [LW-1:0] len,
                       output int acc_cyc);
    int g;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    g = 0;
    acc_cyc = -1;
    while (acc_cyc < 0) begin
      @(negedge clk);
      if (cmd_ready) acc_cyc = cyc;
      else if (++g > 200) begin
        chk("cmd_accept_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = LW'($urandom);
  endtask

  // Reference model of one command: effective length, wrapped addresses, data.
  task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [LW-1:0] len,
                         input bit dir);
    int n;
    int g;
    int d0;
    int acc;
    int idx;
    logic [31:0] d;
    logic [31:0] wd[$];
    n = (len == 0) ? 1 : ((int'(len) > MB) ? MB : int'(len));
    for (int i = 0; i < n; i++) begin
      if (wr) d = dir ? 32'hA0 + 32'(i) : $urandom;
      else    d = dir ? 32'hDEAD0000 + 32'(i) : $urandom;
      exp_bus.push_back('{wr, a + 32'(4 * i), wr ? d : 32'd0});
      if (wr) wd.push_back(d);
      else begin
        slave_q.push_back(d);
        exp_rd.push_back(d);
      end
    end
    if (wr) wdata = wd[0];
    issue(wr, a, len, acc);
    cmd_q.push_back('{wr, 1'b0, acc + 1});
    d0 = done_cnt;
    if (wr) begin
      idx = 0;
      g = 0;
      while (idx < n && g < 2000) begin
        @(negedge clk);
        g++;
        if (wdata_ack) begin
          idx++;
          @(posedge clk);
          #1;
          wdata = (idx < n) ? wd[idx] : $urandom;
        end
      end
    end
    g = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    exp_bus.delete();
    exp_rd.delete();
    slave_q.delete();
    cmd_q.delete();
    started = 0;
    @(negedge clk);
    mon_en = 1;
  endtask

  initial begin
    int acc;
    int g;
    int d0;
    bit saw_done;
    logic [31:0] ra;
    n_rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_read", {63'd0, read}, 64'd0);
    chk("rst_write", {63'd0, write}, 64'd0);
    chk("rst_wdata_ack", {63'd0, wdata_ack}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
    chk("rst_address", 64'(address), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    mon_en = 1;

    // Directed cases
    sl_mode = 0;
    lat_max = 1;
    run_cmd(1'b1, 32'h100, 5'd4, 1'b1);
    sl_mode = 2;
    hold = 0;
    run_cmd(1'b1, 32'h100, 5'd4, 1'b1);
    chk("stall_cycles", 64'(hold), 64'd3);
    sl_mode = 0;
    run_cmd(1'b0, 32'h200, 5'd3, 1'b1);
    run_cmd(1'b1, 32'h40, 5'd0, 1'b0);
    run_cmd(1'b0, 32'h80, 5'd20, 1'b0);
    run_cmd(1'b1, 32'hFFFFFFFC, 5'd2, 1'b0);
    run_cmd(1'b0, 32'hFFFFFFFC, 5'd2, 1'b0);

    // Reset during beat 2 of a 4-beat write
    mon_en = 0;
    wdata = 32'h5555AAAA;
    issue(1'b1, 32'h300, 5'd4, acc);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(write && address == 32'h304) && g < 20);
    chk("midrst_beat2_addr", 64'(address), 64'h304);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(negedge clk);
    chk("midrst_write", {63'd0, write}, 64'd0);
    chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("midrst_address", 64'(address), 64'd0);
    saw_done = done;
    repeat (5) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
    started = 0;
    mon_en = 1;

    // Read that never gets readdatavalid
    no_resp = 1;
    exp_bus.push_back('{1'b0, 32'h400, 32'd0});
    issue(1'b0, 32'h400, 5'd3, acc);
    cmd_q.push_back('{1'b0, 1'b1, acc + 1});
    d0 = done_cnt;
`ifdef RD_TIMEOUT_EN
    g = 0;
    while (done_cnt == d0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    chk("timeout_done_seen", 64'(done_cnt - d0), 64'd1);
    no_resp = 0;
    run_cmd(1'b0, 32'h500, 5'd2, 1'b0);
`else
    repeat (40) @(posedge clk);
    chk("stuck_no_done", 64'(done_cnt - d0), 64'd0);
    @(negedge clk);
    chk("stuck_read_low", {63'd0, read}, 64'd0);
    chk("stuck_not_ready", {63'd0, cmd_ready}, 64'd0);
    no_resp = 0;
    do_reset();
`endif

    // Randomized commands with random stalls and read latency
    sl_mode = 1;
    lat_max = 4;
    repeat (40) begin
      if ($urandom_range(3, 0) == 0) ra = 32'hFFFFFFC0 + ($urandom_range(15, 0) << 2);
      else ra = $urandom & ~32'h3;
      run_cmd(1'($urandom_range(1, 0)), ra, LW'($urandom_range(20, 0)), 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("end_exp_bus_empty", 64'(exp_bus.size()), 64'd0);
    chk("end_exp_rd_empty", 64'(exp_rd.size()), 64'd0);
    chk("end_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_burst_master.md
Name: avalon_burst_master

Overview:
- Parametrised Avalon-MM master: the SRAM access engine for the edge-detection datapath.
- Accepts one command per transaction from the controller: read or write, base address, beat count.
- Issues sequential single-word Avalon transfers at incrementing addresses.
- Honours waitrequest and readdatavalid, so stalling slaves and variable read latency are supported.

Parameters:
- DATA_W, 32, data bus width in bits; must be a multiple of 8.
- ADDR_W, 32, byte address width.
- MAX_BURST, 16, maximum beats per command; LEN_W = $clog2(MAX_BURST+1).
- TIMEOUT_CYC, 255, read-response timeout in cycles; used only with RD_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at posedge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  base byte address
- cmd_len  in  LEN_W  beat count; 0 treated as 1; values > MAX_BURST clamped to MAX_BURST
- wdata  in  DATA_W  current write beat, held until wdata_ack
- wdata_ack  out  1  pulse: current write beat accepted by slave
- rdata  out  DATA_W  registered read beat
- rdata_valid  out  1  one-cycle pulse per read beat
- done  out  1  one-cycle pulse at end of command
- error  out  1  valid with done; read timeout occurred
- address  out  ADDR_W  Avalon address (registered)
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  DATA_W  Avalon writedata
- waitrequest  in  1  Avalon slave stall
- readdata  in  DATA_W  Avalon read data
- readdatavalid  in  1  Avalon read data valid

Behaviour:
- Reset: n_rst sampled low at posedge forces state IDLE and clears address, beat counter, rdata, rdata_valid, done, error. read/write/wdata_ack are 0 in the following cycle. Reset mid-transfer aborts the transfer with no done pulse.
- States: IDLE, WR, RD_CMD, RD_WAIT, DONE.
- IDLE: cmd_ready=1. On accept, latch address<=cmd_addr and beats_left<=effective length. Go to WR if cmd_write, else RD_CMD.
- WR: write=1, writedata=wdata (combinational pass-through; 0 outside WR).
  - Beat accepted when write && !waitrequest; wdata_ack=1 combinationally in that cycle.
  - On acceptance: address += DATA_W/8 and beats_left decrements.
  - Stay in WR if beats remain (controller presents the next wdata in the next cycle); otherwise go to DONE.
- RD_CMD: read=1 until !waitrequest, then go to RD_WAIT with read=0.
- RD_WAIT: read=0. On readdatavalid, rdata<=readdata and rdata_valid=1 in the next cycle. Then:
  - beats remain: address += DATA_W/8, go to RD_CMD;
  - otherwise: go to DONE.
  - rdata_valid of the last beat coincides with the DONE cycle.
  - readdatavalid outside RD_WAIT is ignored. One outstanding read at a time.
- DONE: done=1 for one cycle, cmd_ready=0, then IDLE. Minimum one idle cycle between commands.
- Latency: accept at edge N gives write/read=1 in cycle N+1. With zero waitrequest, a write of L beats takes L cycles plus DONE. A read beat takes 2 cycles plus the slave latency.
- Address arithmetic wraps modulo 2^ADDR_W without error.
- cmd_* inputs are ignored outside IDLE; wdata is sampled only in WR.

Optional Feature:
- Macro RD_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT and clears on entry.
  - When it reaches TIMEOUT_CYC with no readdatavalid, remaining beats are dropped and the block goes to DONE with done=1 and error=1. No rdata_valid is issued for the timed-out beat.
  - error is cleared on the next command accept.
- Undefined: no counter, error tied 0, RD_WAIT waits indefinitely.

Test Plan:
- Write, cmd_addr=0x100, len=4, waitrequest=0, wdata=A0..A3: write high 4 consecutive cycles at addresses 0x100/0x104/0x108/0x10C carrying A0..A3; 4 wdata_ack pulses; done the cycle after the last beat.
- Same write with waitrequest high 3 cycles on beat 2: address 0x104 and writedata A1 held stable for 4 cycles; wdata_ack only on the final cycle; total beats still 4.
- Read, cmd_addr=0x200, len=3, readdatavalid 2 cycles after acceptance, readdata=0xDEAD0000+n: rdata_valid pulses with 0xDEAD0000, 0xDEAD0001, 0xDEAD0002; addresses 0x200/0x204/0x208; done aligned with the third rdata_valid.
- cmd_len=0 → single beat; cmd_len=20 → 16 beats. Address 0xFFFFFFFC with len=2 → second beat at 0x00000000.
- n_rst low during beat 2 of a 4-beat write: write=0 the next cycle, state IDLE, cmd_ready=1, no done pulse.
- RD_TIMEOUT_EN, TIMEOUT_CYC=8, readdatavalid never asserted: done=1 and error=1 exactly 8 cycles after entering RD_WAIT, no rdata_valid. Without the macro, the block stays in RD_WAIT.
